packed_signed_unpacker: RTL and testbench
=========================================

# packed_signed_unpacker

Stream consumer for 8-bit `struct packed signed { bit [3:0] lo; bit [3:0] hi; }` records. Each accepted record is split into its two fields, which leave on a nibble stream in declaration order: `lo` first, then `hi`. The block also keeps a running signed sum and a count of the records it has accepted. It sits downstream of any producer that packs these records, and is the read side of the packed-signed record format.

## Interface
Parameters:
- SUM_W, 16, accumulator width (≥ 8); the record value is sign-extended to this width.
- CNT_W, 8, record-counter width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  record present.
- in_ready  output  1  block accepts the record this cycle.
- in_data  input  8  packed record; [7:4] = lo, [3:0] = hi; the full byte is a signed value.
- clr  input  1  synchronous clear of acc and count.
- out_valid  output  1  nibble present.
- out_ready  input  1  downstream accepts the nibble.
- out_nibble  output  4  current field.
- out_first  output  1  current field is lo.
- out_last  output  1  current field is hi.
- out_rec  output  SUM_W  buffered record, sign-extended; stable while out_valid.
- acc  output  SUM_W  running sum of accepted records, wraps mod 2^SUM_W.
- count  output  CNT_W  number of accepted records, wraps.

## Operation
- Buffer: one 8-bit record register.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1. An accept moves the FSM to LO.
  - LO: out_valid=1, out_nibble=buf[7:4], out_first=1. Handshake (out_valid & out_ready) moves it to HI. in_ready=0.
  - HI: out_valid=1, out_nibble=buf[3:0], out_last=1, in_ready=out_ready.
    - Handshake with no accept: go to EMPTY.
    - Handshake with a simultaneous accept: load the new record and go to LO.
- Accept means in_valid & in_ready. On accept, buf <= in_data.
- in_ready is combinational from state and out_ready. No combinational path from in_valid to out_*.
- Accumulator, on accept: acc <= acc + sext(in_data); count <= count + 1.
  - Both wrap silently; no saturation and no overflow flag.
- clr:
  - With no accept: acc <= 0, count <= 0.
  - Same cycle as an accept: acc <= sext(in_data), count <= 1 (clear applies first, then the add).
  - clr does not affect the FSM or the buffer.
- Output stability: while out_valid=1 and out_ready=0, out_nibble, out_first, out_last and out_rec hold stable.
- Reset values: state=EMPTY, buf=0, acc=0, count=0.
  - Outputs during and after reset: out_valid=0, out_nibble=0, out_first=0, out_last=0, out_rec=0, in_ready=1 (first cycle after rst deasserts).
  - rst has priority over everything, including clr and handshakes.
  - Reset mid-record drops the buffered record. Its remaining nibble is never emitted.

## Timing
- Latency: a record accepted in cycle N has its lo nibble valid in cycle N+1. With out_ready=1, hi is valid in N+2.
- Throughput: one record per 2 cycles sustained (accept overlaps the HI handshake). Per record, out_valid pulses: lo, hi, lo, hi...
- acc and count reflect an accept in cycle N from cycle N+1.
- Backpressure: out_ready low stalls in place. in_ready stays 0 in LO, and in HI while out_ready=0.

## Test plan
- Reset, then in_data=8'd200 (0xC8) accepted:
  - next cycle: out_nibble=4'hC, out_first=1, out_rec=16'hFFC8 (−56);
  - following cycle: out_nibble=4'h8, out_last=1;
  - acc=16'hFFC8, count=1.
- Back-to-back 0xC8 then 0x7F, in_valid and out_ready held high:
  - nibble sequence C,8,7,F with no bubbles after the first;
  - 0x7F accepted in the same cycle as the 0x8 handshake;
  - final acc=16'h0047 (71), count=2.
- 0x81 accepted, out_ready=0 for 3 cycles:
  - out_nibble=4'h8 with out_first=1 held stable, in_ready=0 throughout;
  - release gives 8 then 1;
  - out_rec=16'hFF81.
- SUM_W=8 instance: 0x7F then 0x01 gives acc=8'h80 (−128). A further 0x80 wraps acc to 8'h00; count=3.
- clr asserted with no accept: acc and count go to 0 next cycle. clr in the same cycle as accepting 0xF0: acc=16'hFFF0, count=1.
- rst asserted in the cycle LO is presented (0xA5 buffered):
  - next cycle: out_valid=0, in_ready=1, acc=0, count=0;
  - no 0x5 nibble ever emitted;
  - a following 0x12 yields 1,2 normally.

Source files
------------

// File: rtl/packed_signed_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : packed_signed_unpacker
// Description : Splits signed packed {lo,hi} byte records into a lo-then-hi
//               nibble stream, keeping a running signed sum and record count.
// Revision    : 1.0 - initial release
// ============================================================================
module packed_signed_unpacker #(
    parameter int SUM_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_nibble,
    output logic             out_first,
    output logic             out_last,
    output logic [SUM_W-1:0] out_rec,
    output logic [SUM_W-1:0] acc,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_lo    = 2'd1;
    localparam logic [1:0] c_hi    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [7:0]       r_buf;
    logic [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_handshake;
    logic [SUM_W-1:0] w_in_sext;
    logic [SUM_W-1:0] w_buf_sext;

    // A zero-width replication is illegal, so the narrowest accumulator
    // takes the byte as-is.
    generate
        if (SUM_W > 8) begin : g_sext_wide
            assign w_in_sext  = {{(SUM_W-8){in_data[7]}}, in_data};
            assign w_buf_sext = {{(SUM_W-8){r_buf[7]}}, r_buf};
        end else begin : g_sext_narrow
            assign w_in_sext  = in_data;
            assign w_buf_sext = r_buf;
        end
    endgenerate

    // Accepting during the HI handshake keeps one record every two cycles.
    assign in_ready    = (r_state == c_empty) || ((r_state == c_hi) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign out_valid   = (r_state == c_lo) || (r_state == c_hi);
    assign w_handshake = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_empty: if (w_accept)    w_state_nxt = c_lo;
            c_lo:    if (w_handshake) w_state_nxt = c_hi;
            c_hi:    if (w_handshake) w_state_nxt = w_accept ? c_lo : c_empty;
            default:                  w_state_nxt = c_empty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_empty;
            r_buf   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_buf <= in_data;
            end
        end
    end

    // A clear coinciding with an accept restarts the sum at that record.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_acc   <= w_accept ? w_in_sext : '0;
            r_count <= w_accept ? CNT_W'(1) : '0;
        end else if (w_accept) begin
            r_acc   <= r_acc + w_in_sext;
            r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        out_nibble = 4'd0;
        out_first  = 1'b0;
        out_last   = 1'b0;
        case (r_state)
            c_lo: begin
                out_nibble = r_buf[7:4];
                out_first  = 1'b1;
            end
            c_hi: begin
                out_nibble = r_buf[3:0];
                out_last   = 1'b1;
            end
            default: begin
                out_nibble = 4'd0;
            end
        endcase
    end

    assign out_rec = w_buf_sext;
    assign acc     = r_acc;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_packed_signed_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_packed_signed_unpacker
// Description : Directed and random checks of packed_signed_unpacker against
//               a nibble-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_packed_signed_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'd0;
    logic        clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_nibble;
    logic        out_first;
    logic        out_last;
    logic [15:0] out_rec;
    logic [15:0] acc;
    logic [7:0]  count;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_data8 = 8'd0;
    logic        out_valid8;
    logic [3:0]  out_nibble8;
    logic        out_first8;
    logic        out_last8;
    logic [7:0]  out_rec8;
    logic [7:0]  acc8;
    logic [7:0]  count8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  qn[$];
    bit          qf[$];
    logic [7:0]  qr[$];
    logic [15:0] m_acc = 16'd0;
    logic [7:0]  m_cnt = 8'd0;

    always #5 clk = ~clk;

    packed_signed_unpacker #(.SUM_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_nibble(out_nibble), .out_first(out_first),
        .out_last(out_last), .out_rec(out_rec), .acc(acc), .count(count)
    );

    packed_signed_unpacker #(.SUM_W(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_data(in_data8), .clr(1'b0), .out_valid(out_valid8),
        .out_ready(1'b1), .out_nibble(out_nibble8), .out_first(out_first8),
        .out_last(out_last8), .out_rec(out_rec8), .acc(acc8), .count(count8)
    );

    function automatic logic [15:0] sx(input logic [7:0] d);
        return {{8{d[7]}}, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive, compare against the model, advance the
    // model by one rising edge, and return at the next falling edge.
    task automatic cyc(input bit r, input bit v, input logic [7:0] d,
                       input bit o, input bit c);
        bit exp_valid, exp_ready, hs, acc_ok;
        rst = r; in_valid = v; in_data = d; out_ready = o; clr = c;
        #1;
        exp_valid = (qn.size() != 0);
        exp_ready = (qn.size() == 0) || (qn.size() == 1 && o);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_valid) begin
            chk("out_nibble", 32'(out_nibble), 32'(qn[0]));
            chk("out_first", 32'(out_first), 32'(qf[0]));
            chk("out_last", 32'(out_last), 32'(!qf[0]));
            chk("out_rec", 32'(out_rec), 32'(sx(qr[0])));
        end
        chk("acc", 32'(acc), 32'(m_acc));
        chk("count", 32'(count), 32'(m_cnt));
        hs     = exp_valid && o;
        acc_ok = v && exp_ready;
        if (r) begin
            qn.delete(); qf.delete(); qr.delete();
            m_acc = 16'd0; m_cnt = 8'd0;
        end else begin
            if (hs) begin
                void'(qn.pop_front()); void'(qf.pop_front()); void'(qr.pop_front());
            end
            if (acc_ok) begin
                qn.push_back(d[7:4]); qf.push_back(1'b1); qr.push_back(d);
                qn.push_back(d[3:0]); qf.push_back(1'b0); qr.push_back(d);
            end
            if (c) begin
                m_acc = acc_ok ? sx(d) : 16'd0;
                m_cnt = acc_ok ? 8'd1 : 8'd0;
            end else if (acc_ok) begin
                m_acc = m_acc + sx(d);
                m_cnt = m_cnt + 8'd1;
            end
        end
        @(negedge clk);
    endtask

    task automatic push8(input logic [7:0] d);
        int t = 0;
        while (!in_ready8 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready8", 32'(in_ready8), 32'(1'b1));
        in_valid8 = 1'b1;
        in_data8  = d;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst_in_ready", 32'(in_ready), 32'(1'b1));
        chk("rst_nibble", 32'(out_nibble), 32'(4'h0));
        chk("rst_first", 32'(out_first), 32'(1'b0));
        chk("rst_last", 32'(out_last), 32'(1'b0));
        chk("rst_rec", 32'(out_rec), 32'(16'h0));
        chk("rst_acc", 32'(acc), 32'(16'h0));
        chk("rst_count", 32'(count), 32'(8'h0));

        // Single record 0xC8
        cyc(0, 1, 8'hC8, 1, 0);
        #1;
        chk("c8_lo_nib", 32'(out_nibble), 32'(4'hC));
        chk("c8_lo_first", 32'(out_first), 32'(1'b1));
        chk("c8_rec", 32'(out_rec), 32'(16'hFFC8));
        cyc(0, 0, 8'h00, 1, 0);
        #1;
        chk("c8_hi_nib", 32'(out_nibble), 32'(4'h8));
        chk("c8_hi_last", 32'(out_last), 32'(1'b1));
        chk("c8_acc", 32'(acc), 32'(16'hFFC8));
        chk("c8_count", 32'(count), 32'(8'd1));
        cyc(0, 0, 8'h00, 1, 0);

        // Clear without accept, then back-to-back C8, 7F
        cyc(0, 0, 8'h00, 1, 1);
        #1;
        chk("clr_acc", 32'(acc), 32'(16'h0));
        chk("clr_count", 32'(count), 32'(8'd0));
        cyc(0, 1, 8'hC8, 1, 0);
        cyc(0, 1, 8'h7F, 1, 0);
        cyc(0, 1, 8'h7F, 1, 0);
        #1;
        chk("b2b_lo7", 32'(out_nibble), 32'(4'h7));
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        #1;
        chk("b2b_acc", 32'(acc), 32'(16'h0047));
        chk("b2b_count", 32'(count), 32'(8'd2));

        // Backpressure on 0x81
        cyc(0, 1, 8'h81, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 8'h33, 0, 0);
            #1;
            chk("bp_nib", 32'(out_nibble), 32'(4'h8));
            chk("bp_first", 32'(out_first), 32'(1'b1));
            chk("bp_in_ready", 32'(in_ready), 32'(1'b0));
        end
        cyc(0, 0, 8'h00, 1, 0);
        #1;
        chk("bp_hi_nib", 32'(out_nibble), 32'(4'h1));
        chk("bp_rec", 32'(out_rec), 32'(16'hFF81));
        cyc(0, 0, 8'h00, 1, 0);

        // Clear coinciding with an accept of 0xF0
        cyc(0, 1, 8'hF0, 1, 1);
        #1;
        chk("clracc_acc", 32'(acc), 32'(16'hFFF0));
        chk("clracc_count", 32'(count), 32'(8'd1));
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);

        // Reset while the lo nibble of 0xA5 is presented
        cyc(0, 1, 8'hA5, 1, 0);
        cyc(1, 0, 8'h00, 1, 0);
        #1;
        chk("rmid_valid", 32'(out_valid), 32'(1'b0));
        chk("rmid_ready", 32'(in_ready), 32'(1'b1));
        chk("rmid_acc", 32'(acc), 32'(16'h0));
        chk("rmid_count", 32'(count), 32'(8'd0));
        chk("rmid_rec", 32'(out_rec), 32'(16'h0));
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 1, 8'h12, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                8'($urandom), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 29) == 0));
        end
        repeat (4) cyc(0, 0, 8'h00, 1, 0);

        // Narrow accumulator wraps
        push8(8'h7F);
        push8(8'h01);
        chk("w8_acc80", 32'(acc8), 32'(8'h80));
        push8(8'h80);
        chk("w8_acc00", 32'(acc8), 32'(8'h00));
        chk("w8_count", 32'(count8), 32'(8'd3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
